// File: rtl/debounce_filter.sv
// debounce_filter: per-bit glitch filter for slow, already-synchronised inputs.
// A bit's output level flips only after its input has disagreed with it for
// HOLD consecutive qualifying ticks; rise/fall strobe for one cycle on a flip.
module debounce_filter #(
    parameter int unsigned    W       = 1,
    parameter int unsigned    HOLD    = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    localparam int unsigned     CW      = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(HOLD - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } chan_state_e;

    chan_state_e   st      [W];
    logic [CW-1:0] cnt_q   [W];
    logic [CW-1:0] cnt_d   [W];
    logic [W-1:0]  q_q,    q_d;
    logic [W-1:0]  rise_q, rise_d;
    logic [W-1:0]  fall_q, fall_d;

    // Per-channel next state: count mismatched ticks, flip on the HOLD-th one.
    always_comb begin
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < W; i++) begin
            cnt_d[i] = '0;
            st[i]    = (d[i] != q_q[i]) ? ST_PENDING : ST_STABLE;
            if (st[i] == ST_PENDING) begin
                if (!tick) begin
                    cnt_d[i] = cnt_q[i];
                end else if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else begin
                    // Pending implies d != q, so the new level alone gives the direction.
                    q_d[i]    = d[i];
                    rise_d[i] = d[i];
                    fall_d[i] = ~d[i];
                end
            end
        end
    end

    // State register with synchronous reset overriding any flip on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int unsigned i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int unsigned i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule
